// File: rtl/dmem_responder_if.sv
// Request/response channel between the core's memory stage (master) and dmem_responder (slave).
interface dmem_responder_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [2:0]        req_funct3;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, WAIT_CYCLES wait states, little-endian byte storage.
// Macro DMEM_ERR_EN enables access-fault detection; without it addresses wrap/align and never fault.
module dmem_responder #(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h0200_0000,
    parameter int                MEM_DEPTH   = 1024,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int OFF_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0]        mem_q [MEM_DEPTH];

    logic              cur_we;
    logic [AWIDTH-1:0] cur_addr;
    logic [DWIDTH-1:0] cur_wdata;
    logic [2:0]        cur_funct3;
    logic [AWIDTH-1:0] offset;
    logic [OFF_W-1:0]  idx;
    logic [2:0]        size;
    logic              fault;
    logic [31:0]       raw_word;
    logic [31:0]       load_data;
    logic              enter_resp;
    logic              mem_we;

    // While IDLE the request is still on the bus; later stages use the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we     = bus.req_we;
            cur_addr   = bus.req_addr;
            cur_wdata  = bus.req_wdata;
            cur_funct3 = bus.req_funct3;
        end else begin
            cur_we     = we_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
            cur_funct3 = funct3_q;
        end
    end

    always_comb begin
        case (cur_funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
    end

    assign offset = cur_addr - BASE_ADDR;

`ifdef DMEM_ERR_EN
    logic [AWIDTH:0] end_off;
    logic            illegal;
    logic            misaligned;

    assign end_off    = {1'b0, offset} + {{(AWIDTH-2){1'b0}}, size};
    assign illegal    = (cur_funct3 == 3'b011) || (cur_funct3[2:1] == 2'b11);
    assign misaligned = ((size == 3'd2) && cur_addr[0]) ||
                        ((size == 3'd4) && (cur_addr[1:0] != 2'b00));
    assign fault      = illegal || misaligned || (end_off > (AWIDTH+1)'(MEM_DEPTH));
    assign idx        = offset[OFF_W-1:0];
`else
    logic unused_offset_hi;

    assign unused_offset_hi = ^offset[AWIDTH-1:OFF_W];
    assign fault            = 1'b0;
    // Truncating the offset wraps it into the array; low bits are cleared to align to the access size.
    assign idx = {offset[OFF_W-1:2], offset[1] & (size != 3'd4), offset[0] & (size == 3'd1)};
`endif

    assign raw_word = {mem_q[idx + OFF_W'(3)], mem_q[idx + OFF_W'(2)],
                       mem_q[idx + OFF_W'(1)], mem_q[idx]};

    always_comb begin
        case (size)
            3'd1:    load_data = cur_funct3[2] ? {24'd0, raw_word[7:0]}
                                               : {{24{raw_word[7]}}, raw_word[7:0]};
            3'd2:    load_data = cur_funct3[2] ? {16'd0, raw_word[15:0]}
                                               : {{16{raw_word[15]}}, raw_word[15:0]};
            default: load_data = raw_word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    funct3_d = bus.req_funct3;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            state_d = RESP;
            rdata_d = (cur_we || fault) ? '0 : load_data;
            err_d   = fault;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'd0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Stores commit exactly once, on the edge that enters RESP; storage is never cleared by reset.
    assign mem_we = enter_resp && cur_we && !fault && rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= cur_wdata[7:0];
            if (size != 3'd1) begin
                mem_q[idx + OFF_W'(1)] <= cur_wdata[15:8];
            end
            if (size == 3'd4) begin
                mem_q[idx + OFF_W'(2)] <= cur_wdata[23:16];
                mem_q[idx + OFF_W'(3)] <= cur_wdata[31:24];
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
